// File: rtl/lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen -- parametrised Galois LFSR pseudo-random generator
//
// Shifts toward the MSB; the bit leaving the top (q[WIDTH-1]) is fed back
// into bit 0 and XORed into every tap position selected by POLY. Alongside
// the generator, the block measures the cycle length. It counts enabled steps
// from the last reference state (the reset seed or the last loaded seed)
// until the register returns to that state.
//
// Parameters:
//   WIDTH      register width, 3..32
//   POLY       feedback coefficients c[WIDTH-1:0] of x^WIDTH + sum(c_i x^i);
//              c[0] is implicitly 1 (bit 0 always receives the feedback bit)
//   RESET_SEED non-zero state used at reset and in place of a zero seed
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   en            advance one step this cycle
//   load          synchronous seed load; wins over en
//   seed          value to load
//   q             current LFSR state
//   serial_out    q[WIDTH-1]
//   seed_err      one-cycle pulse after a load with seed == 0
//   period        last measured period in steps
//   period_valid  one-cycle pulse when period is updated
//
// Control semantics: there is no back-pressure. Each rising edge samples load
// and en once. load=1 always takes effect that cycle, and en is ignored.
// With load=0 and en=1 the generator makes exactly one step. With both low,
// the state holds.
// ---------------------------------------------------------------------------
module lfsr_gen #(
    parameter int               WIDTH      = 6,
    parameter logic [WIDTH-1:0] POLY       = 6'b100001,
    parameter logic [WIDTH-1:0] RESET_SEED = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             seed_err,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    logic [WIDTH-1:0] ref_q;     // state the current measurement started from
    logic [WIDTH-1:0] cnt;       // enabled steps since ref_q
    logic [WIDTH-1:0] step_q;    // q after one Galois step
    logic [WIDTH-1:0] cnt_inc;
    logic             fb;

    // Galois step: bit 0 takes the feedback bit. Every other bit takes its
    // lower neighbour, XORed with the feedback bit where POLY has a tap.
    always_comb begin
        fb        = q[WIDTH-1];
        step_q    = '0;
        step_q[0] = fb;
        for (int i = 1; i < WIDTH; i++) begin
            step_q[i] = q[i-1] ^ (POLY[i] & fb);
        end
    end

    // Cannot overflow from a non-zero state: every such state lies on a cycle
    // of at most 2^WIDTH-1 steps that returns to ref_q.
    assign cnt_inc = cnt + {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q            <= RESET_SEED;
            ref_q        <= RESET_SEED;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            seed_err     <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-asserted below.
            period_valid <= 1'b0;
            seed_err     <= 1'b0;
            if (load) begin
                // A load restarts measurement. Any partial count is discarded
                // and period keeps its previous value.
                cnt <= '0;
                if (seed == '0) begin
                    // The all-zero state would lock up the register.
                    q        <= RESET_SEED;
                    ref_q    <= RESET_SEED;
                    seed_err <= 1'b1;
                end else begin
                    q     <= seed;
                    ref_q <= seed;
                end
            end else if (en) begin
                q <= step_q;
                if (step_q == ref_q) begin
                    period       <= cnt_inc;
                    period_valid <= 1'b1;
                    cnt          <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    assign serial_out = q[WIDTH-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_gen -- bench for lfsr_gen
//
// Two instances share clk, en, load and seed:
//   dut_a : default polynomial x^6+x^5+1 (maximal length, period 63)
//   dut_b : x^6+x^3+1 (non-primitive, period 9 from 111111)
// Each has its own reset, so dut_b can be reset asynchronously on its own.
// A behavioural model per instance pushes the expected post-edge outputs into
// exp_q while stimulus is driven. The entries are popped and compared once the
// edge has happened.
// ---------------------------------------------------------------------------
module tb_lfsr_gen;

    localparam int          W      = 6;
    localparam logic [W-1:0] RS     = {W{1'b1}};
    localparam logic [W-1:0] POLY_A = 6'b100001;
    localparam logic [W-1:0] POLY_B = 6'b001001;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_a, rst_b;
    logic en, load;
    logic [W-1:0] seed;

    logic [W-1:0] q_a, q_b, period_a, period_b;
    logic         so_a, so_b, se_a, se_b, pv_a, pv_b;

    // First rising edge at 7 ns, then every 10 ns.
    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    lfsr_gen #(.WIDTH(W), .POLY(POLY_A), .RESET_SEED(RS)) dut_a (
        .clk(clk), .rst(rst_a), .en(en), .load(load), .seed(seed),
        .q(q_a), .serial_out(so_a), .seed_err(se_a),
        .period(period_a), .period_valid(pv_a)
    );

    lfsr_gen #(.WIDTH(W), .POLY(POLY_B), .RESET_SEED(RS)) dut_b (
        .clk(clk), .rst(rst_b), .en(en), .load(load), .seed(seed),
        .q(q_b), .serial_out(so_b), .seed_err(se_b),
        .period(period_b), .period_valid(pv_b)
    );

    // ---------------- scoreboard ----------------
    // entry = {q, serial_out, seed_err, period_valid, period}
    logic [2*W+2:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int pv_cnt_a = 0;

    logic [W-1:0] m_q[2], m_ref[2], m_cnt[2], m_per[2];
    logic         m_pv[2], m_se[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Written as shift-then-conditional-XOR with the polynomial (c0 forced).
    function automatic logic [W-1:0] galois(input logic [W-1:0] s, input logic [W-1:0] p);
        logic [W-1:0] t;
        t = s << 1;
        if (s[W-1]) t = t ^ (p | {{(W-1){1'b0}}, 1'b1});
        return t;
    endfunction

    task automatic model_reset(input int i);
        m_q[i] = RS; m_ref[i] = RS; m_cnt[i] = '0; m_per[i] = '0;
        m_pv[i] = 1'b0; m_se[i] = 1'b0;
    endtask

    task automatic model_edge(input int i, input logic r, input logic [W-1:0] p);
        logic [W-1:0] nq;
        if (!r) begin
            model_reset(i);
        end else begin
            m_pv[i] = 1'b0;
            m_se[i] = 1'b0;
            if (load) begin
                m_cnt[i] = '0;
                if (seed == '0) begin
                    m_q[i] = RS; m_ref[i] = RS; m_se[i] = 1'b1;
                end else begin
                    m_q[i] = seed; m_ref[i] = seed;
                end
            end else if (en) begin
                nq = galois(m_q[i], p);
                m_cnt[i] = m_cnt[i] + 1'b1;
                if (nq == m_ref[i]) begin
                    m_per[i] = m_cnt[i];
                    m_pv[i]  = 1'b1;
                    m_cnt[i] = '0;
                end
                m_q[i] = nq;
            end
        end
        exp_q.push_back({m_q[i], m_q[i][W-1], m_se[i], m_pv[i], m_per[i]});
    endtask

    task automatic pop_check(input string nm, input logic [W-1:0] q, input logic so,
                             input logic se, input logic pv, input logic [W-1:0] per);
        logic [2*W+2:0] e;
        if (exp_q.size() == 0) begin
            check_eq({nm, "_queue_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({nm, "_q"},          32'(q),   32'(e[2*W+2:W+3]));
            check_eq({nm, "_serial_out"}, 32'(so),  32'(e[W+2]));
            check_eq({nm, "_seed_err"},   32'(se),  32'(e[W+1]));
            check_eq({nm, "_period_vld"}, 32'(pv),  32'(e[W]));
            check_eq({nm, "_period"},     32'(per), 32'(e[W-1:0]));
        end
    endtask

    // ---------------- driver ----------------
    // Drives one cycle's inputs, records the expectations, then checks 1 ns
    // after the rising edge.
    task automatic cyc(input logic e, input logic l, input logic [W-1:0] s);
        en = e; load = l; seed = s;
        model_edge(0, rst_a, POLY_A);
        model_edge(1, rst_b, POLY_B);
        @(posedge clk);
        #1;
        pop_check("a", q_a, so_a, se_a, pv_a, period_a);
        pop_check("b", q_b, so_b, se_b, pv_b, period_b);
        if (pv_a) pv_cnt_a++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pv_before;
        rst_a = 1'b0; rst_b = 1'b0;
        en = 1'b1; load = 1'b0; seed = '0;
        model_reset(0);
        model_reset(1);

        // Reset sequence: held for 25 ns with en=1.
        #10;
        check_eq("rst_q_a",      32'(q_a),      32'(RS));
        check_eq("rst_q_b",      32'(q_b),      32'(RS));
        check_eq("rst_period_a", 32'(period_a), 32'd0);
        check_eq("rst_pv_a",     32'(pv_a),     32'd0);
        check_eq("rst_se_a",     32'(se_a),     32'd0);
        #15;
        rst_a = 1'b1; rst_b = 1'b1;

        cyc(1'b1, 1'b0, '0); check_eq("seq1", 32'(q_a), 32'h1f);
        cyc(1'b1, 1'b0, '0); check_eq("seq2", 32'(q_a), 32'h3e);
        cyc(1'b1, 1'b0, '0); check_eq("seq3", 32'(q_a), 32'h1d);

        // Full period; dut_b closes its 9-cycle loop along the way.
        for (int k = 4; k <= 63; k++) begin
            cyc(1'b1, 1'b0, '0);
            if (k == 9) begin
                check_eq("np_q9",      32'(q_b),      32'(RS));
                check_eq("np_pv9",     32'(pv_b),     32'd1);
                check_eq("np_period9", 32'(period_b), 32'd9);
            end
        end
        check_eq("full_q",      32'(q_a),      32'(RS));
        check_eq("full_pv",     32'(pv_a),     32'd1);
        check_eq("full_period", 32'(period_a), 32'd63);
        check_eq("full_pv_cnt", 32'(pv_cnt_a), 32'd1);
        for (int k = 0; k < 63; k++) cyc(1'b1, 1'b0, '0);
        check_eq("two_pv_cnt", 32'(pv_cnt_a), 32'd2);
        check_eq("two_q",      32'(q_a),      32'(RS));

        // Enable gating: en = 1,0,0,1.
        cyc(1'b1, 1'b0, '0); check_eq("gate1", 32'(q_a), 32'h1f);
        cyc(1'b0, 1'b0, '0); check_eq("gate2", 32'(q_a), 32'h1f);
        cyc(1'b0, 1'b0, '0); check_eq("gate3", 32'(q_a), 32'h1f);
        cyc(1'b1, 1'b0, '0); check_eq("gate4", 32'(q_a), 32'h3e);
        for (int k = 0; k < 61; k++) cyc(1'b1, 1'b0, '0);
        check_eq("gate_pv",     32'(pv_a),     32'd1);
        check_eq("gate_period", 32'(period_a), 32'd63);
        check_eq("gate_pv_cnt", 32'(pv_cnt_a), 32'd3);

        // Seed load of 000001, with a mid-cycle async reset of dut_b.
        cyc(1'b0, 1'b1, 6'b000001);
        check_eq("load_q", 32'(q_a), 32'h01);
        cyc(1'b1, 1'b0, '0);
        #2 rst_b = 1'b0;
        #1;
        check_eq("async_q_b",   32'(q_b),      32'(RS));
        check_eq("async_per_b", 32'(period_b), 32'd0);
        check_eq("async_pv_b",  32'(pv_b),     32'd0);
        cyc(1'b1, 1'b0, '0);
        rst_b = 1'b1;
        for (int k = 0; k < 61; k++) cyc(1'b1, 1'b0, '0);
        check_eq("seed_q",      32'(q_a),      32'h01);
        check_eq("seed_pv",     32'(pv_a),     32'd1);
        check_eq("seed_period", 32'(period_a), 32'd63);

        // Zero seed.
        cyc(1'b0, 1'b1, '0);
        check_eq("zero_q",   32'(q_a),  32'(RS));
        check_eq("zero_se",  32'(se_a), 32'd1);
        cyc(1'b0, 1'b0, '0);
        check_eq("zero_se2", 32'(se_a), 32'd0);

        // load wins over en.
        cyc(1'b1, 1'b1, 6'b101010);
        check_eq("prio_q",  32'(q_a),  32'h2a);
        check_eq("prio_pv", 32'(pv_a), 32'd0);

        // Abort after 30 steps; new measurement from the loaded seed.
        for (int k = 0; k < 30; k++) cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 6'b010101);
        pv_before = pv_cnt_a;
        for (int k = 0; k < 62; k++) cyc(1'b1, 1'b0, '0);
        check_eq("abort_no_pv",  32'(pv_cnt_a), 32'(pv_before));
        check_eq("abort_period", 32'(period_a), 32'd63);
        cyc(1'b1, 1'b0, '0);
        check_eq("abort_pv", 32'(pv_a), 32'd1);
        check_eq("abort_q",  32'(q_a),  32'h15);

        // Random mix of steps, holds and loads.
        for (int k = 0; k < 200; k++) begin
            cyc(1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0),
                W'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 63)));
        end

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
